ram_1r1w_arbiter: RTL and testbench
===================================

# ram_1r1w_arbiter

Round-robin arbiter that shares one `ram_1r1w` instance between two independent read clients and one write client. Each client uses a valid/ready request channel, and each read client also gets a registered valid/ready response channel. The block drives the RAM's read and write ports so that exactly one RAM operation is issued per cycle. It sits between the decoder stages that share a history or table buffer and the RAM macro itself.

## Interface
Parameters:
- `DATA_WIDTH`, 4: RAM word width.
- `SIZE`, 32: RAM depth in words.
- `NUM_PARTITIONS`, 1: number of mask partitions; must divide `DATA_WIDTH`.
- `ADDR_WIDTH`, `$clog2(SIZE)`: address width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rdN_req_valid` in 1 (N=0,1): read request N valid.
- `rdN_req_ready` out 1: read request N accepted this cycle.
- `rdN_req_addr` in `ADDR_WIDTH`: read address.
- `rdN_req_mask` in `NUM_PARTITIONS`: read partition mask.
- `rdN_resp_valid` out 1: read response N valid.
- `rdN_resp_ready` in 1: consumer of response N ready.
- `rdN_resp_data` out `DATA_WIDTH`: read data, masked by the RAM.
- `wr_req_valid` in 1, `wr_req_ready` out 1: write request handshake.
- `wr_req_addr` in `ADDR_WIDTH`, `wr_req_data` in `DATA_WIDTH`, `wr_req_mask` in `NUM_PARTITIONS`: write request payload.
- `ram_rd_en` out 1, `ram_rd_addr` out `ADDR_WIDTH`, `ram_rd_mask` out `NUM_PARTITIONS`: RAM read port.
- `ram_rd_data` in `DATA_WIDTH`: RAM registered read data, valid the cycle after `ram_rd_en`.
- `ram_wr_en` out 1, `ram_wr_addr` out `ADDR_WIDTH`, `ram_wr_data` out `DATA_WIDTH`, `ram_wr_mask` out `NUM_PARTITIONS`: RAM write port.

## Operation
- **Requesters.** Indices are 0 = rd0, 1 = rd1, 2 = wr.
- **State.**
  - `prio` (2 bits, values 0..2): index of the highest-priority requester.
  - `pending[1:0]`: RAM read in flight per port.
  - `resp_valid[1:0]` and `resp_data[1:0]`: one-entry response register per port.
- **Eligibility.**
  - rdN is eligible iff `rdN_req_valid && !pending[N] && (!resp_valid[N] || rdN_resp_ready)`.
  - wr is eligible iff `wr_req_valid`.
- **Grant.** Combinational. Search starts at `prio` in the order prio, prio+1, prio+2 (mod 3), and the first eligible requester wins. At most one grant per cycle.
- **Grant effects.**
  - The granted requester's `*_req_ready` is 1; all others are 0.
  - Read grant: `ram_rd_en`=1, address and mask forwarded, `ram_wr_en`=0.
  - Write grant: `ram_wr_en`=1, address, data and mask forwarded, `ram_rd_en`=0.
  - No grant: both enables 0. Address, data and mask outputs are don't-care.
- **Priority update.** On any grant, `prio` ← (granted + 1) mod 3. With no grant, `prio` is unchanged.
- **Read pipeline.**
  - Cycle t: grant rdN and set `pending[N]`.
  - Cycle t+1: `ram_rd_data` is valid. `resp_data[N]` ← `ram_rd_data`, `resp_valid[N]` ← 1, `pending[N]` ← 0.
  - Cycle t+2: `rdN_resp_valid`=1.
- **Response drain.** `resp_valid[N]` clears on `rdN_resp_valid && rdN_resp_ready`, unless it is being refilled in the same cycle. Refill has priority; data is never dropped.
- **Throughput.** Each read port is limited to one accepted request per 2 cycles because of the `pending` gate. The aggregate RAM utilisation is up to 1 operation per cycle.
- **Ordering.** A write granted in cycle t is visible to any read granted in cycle t+1 or later. Responses per port are returned in request order; there is at most one outstanding request per port.
- **Masks.** Passed through unmodified; masked-off partitions return 0.
- **Reset (`rst`=0, asynchronous).**
  - `prio`=0, `pending`=0, `resp_valid`=0, `resp_data`=0.
  - All `*_req_ready`, `ram_rd_en` and `ram_wr_en` are forced to 0 while reset is asserted.
  - An in-flight read is discarded and produces no response after reset.

## Timing
- Read latency: 2 cycles from request handshake to `rdN_resp_valid`.
- Write latency: takes effect at the end of the grant cycle; there is no response.
- `*_req_ready` depends combinationally on the valids, `rdN_resp_ready` and state. Requesters must not make valid depend on ready.
- Requests must hold valid and payload stable until ready.
- Response outputs are registered; there is no combinational path from `ram_rd_data` to the response outputs.
- Worst-case wait for an eligible requester: 2 grant cycles (fair 3-way rotation).

## Test plan
- **Single read.** Preload mem[5]=0xA, full mask. rd0 requests addr 5 in cycle 0. Expected: `rd0_req_ready`=1 in cycle 0, `rd0_resp_valid`=1 with data 0xA in cycle 2.
- **Rotation.** All three valid continuously from reset, responses always ready. Expected grants: rd0, rd1, wr, then rd0, rd1, wr; no starvation. Read ports are re-granted when no longer pending.
- **Response backpressure.** rd1 gets a response with `rd1_resp_ready`=0 for 5 cycles while rd1 keeps requesting. Expected: no new rd1 grant, data held stable. The cycle `rd1_resp_ready` rises, rd1 is re-granted, and the next response follows 2 cycles later.
- **Write then read.** wr writes 0x3 to addr 7 in cycle t; rd0 reads addr 7 in cycle t+1. Expected response 0x3. Repeat with `wr_req_mask` partial (`NUM_PARTITIONS`=2, mask 2'b01 over old 0xF): expected 0xF.
- **Masked read.** mem[2]=0xF, `rd0_req_mask`=2'b10 with `NUM_PARTITIONS`=2. Expected response 0xC.
- **Reset mid-read.** Grant rd0, then assert `rst`=0 in cycle t+1. Expected: all readies and RAM enables are 0 while reset is asserted, and after release no `rd0_resp_valid` appears. The first grant after release goes to rd0 (`prio`=0).

Source files
------------

// File: rtl/ram_1r1w_arbiter.sv
// Round-robin arbiter sharing one 1R1W RAM between two read clients and one write client.
// One RAM operation per cycle; read responses come back through a one-entry register per port.
module ram_1r1w_arbiter_rd_port #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  resp_ready,
  input  logic                  grant,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  eligible,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data
);
  logic pending;

  // One read in flight per port; a full, stalled response register blocks new grants.
  assign eligible = req_valid && !pending && (!resp_valid || resp_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      pending <= grant;
      if (pending) begin
        resp_valid <= 1'b1;
        resp_data  <= ram_rd_data;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end
endmodule

module ram_1r1w_arbiter #(
  parameter int DATA_WIDTH     = 4,
  parameter int SIZE           = 32,
  parameter int NUM_PARTITIONS = 1,
  parameter int ADDR_WIDTH     = $clog2(SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd0_req_valid,
  output logic                      rd0_req_ready,
  input  logic [ADDR_WIDTH-1:0]     rd0_req_addr,
  input  logic [NUM_PARTITIONS-1:0] rd0_req_mask,
  output logic                      rd0_resp_valid,
  input  logic                      rd0_resp_ready,
  output logic [DATA_WIDTH-1:0]     rd0_resp_data,
  input  logic                      rd1_req_valid,
  output logic                      rd1_req_ready,
  input  logic [ADDR_WIDTH-1:0]     rd1_req_addr,
  input  logic [NUM_PARTITIONS-1:0] rd1_req_mask,
  output logic                      rd1_resp_valid,
  input  logic                      rd1_resp_ready,
  output logic [DATA_WIDTH-1:0]     rd1_resp_data,
  input  logic                      wr_req_valid,
  output logic                      wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]     wr_req_addr,
  input  logic [DATA_WIDTH-1:0]     wr_req_data,
  input  logic [NUM_PARTITIONS-1:0] wr_req_mask,
  output logic                      ram_rd_en,
  output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
  output logic [NUM_PARTITIONS-1:0] ram_rd_mask,
  input  logic [DATA_WIDTH-1:0]     ram_rd_data,
  output logic                      ram_wr_en,
  output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic [NUM_PARTITIONS-1:0] ram_wr_mask
);
  localparam int NUM_RD  = 2;
  localparam int NUM_REQ = 3;

  logic [NUM_RD-1:0]                 rd_req_valid, rd_resp_ready, rd_elig, rd_resp_valid;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_resp_data;
  logic [NUM_REQ-1:0]                elig, gnt;
  logic [1:0]                        prio, gnt_idx, rot_idx;
  logic [2:0]                        rot_sum;
  logic                              found;

  assign rd_req_valid  = {rd1_req_valid, rd0_req_valid};
  assign rd_resp_ready = {rd1_resp_ready, rd0_resp_ready};

  for (genvar n = 0; n < NUM_RD; n++) begin : g_rd
    ram_1r1w_arbiter_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (rd_req_valid[n]),
      .resp_ready (rd_resp_ready[n]),
      .grant      (gnt[n]),
      .ram_rd_data(ram_rd_data),
      .eligible   (rd_elig[n]),
      .resp_valid (rd_resp_valid[n]),
      .resp_data  (rd_resp_data[n])
    );
  end

  // Gating with rst keeps every ready and RAM enable low while reset is held.
  assign elig = {wr_req_valid, rd_elig} & {NUM_REQ{rst}};

  always_comb begin
    gnt     = '0;
    gnt_idx = prio;
    found   = 1'b0;
    rot_sum = '0;
    rot_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot_sum = {1'b0, prio} + 3'(k);
      rot_idx = (rot_sum >= 3'(NUM_REQ)) ? 2'(rot_sum - 3'(NUM_REQ)) : rot_sum[1:0];
      if (!found && elig[rot_idx]) begin
        found        = 1'b1;
        gnt[rot_idx] = 1'b1;
        gnt_idx      = rot_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      prio <= '0;
    else if (|gnt) prio <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  assign rd0_req_ready  = gnt[0];
  assign rd1_req_ready  = gnt[1];
  assign wr_req_ready   = gnt[2];

  assign ram_rd_en      = gnt[0] | gnt[1];
  assign ram_rd_addr    = gnt[1] ? rd1_req_addr : rd0_req_addr;
  assign ram_rd_mask    = gnt[1] ? rd1_req_mask : rd0_req_mask;
  assign ram_wr_en      = gnt[2];
  assign ram_wr_addr    = wr_req_addr;
  assign ram_wr_data    = wr_req_data;
  assign ram_wr_mask    = wr_req_mask;

  assign rd0_resp_valid = rd_resp_valid[0];
  assign rd1_resp_valid = rd_resp_valid[1];
  assign rd0_resp_data  = rd_resp_data[0];
  assign rd1_resp_data  = rd_resp_data[1];
endmodule

// File: tb/tb_ram_1r1w_arbiter.sv
// Bench for ram_1r1w_arbiter: behavioural RAM, spec-level reference model, directed and random scenarios.
module tb_ram_1r1w_arbiter;
  localparam int DW = 4, SZ = 32, NP = 2, AW = 5, PW = DW / NP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         rq_v, rq_rdy, rs_v, rs_rdy;
  logic [1:0][AW-1:0] rq_a;
  logic [1:0][NP-1:0] rq_m;
  logic [1:0][DW-1:0] rs_d;
  logic               wv, wrdy;
  logic [AW-1:0]      wa;
  logic [DW-1:0]      wd;
  logic [NP-1:0]      wm;
  logic               ram_rd_en, ram_wr_en;
  logic [AW-1:0]      ram_rd_addr, ram_wr_addr;
  logic [NP-1:0]      ram_rd_mask, ram_wr_mask;
  logic [DW-1:0]      ram_rd_data, ram_wr_data;

  ram_1r1w_arbiter #(.DATA_WIDTH(DW), .SIZE(SZ), .NUM_PARTITIONS(NP)) dut (
    .clk(clk), .rst(rst),
    .rd0_req_valid(rq_v[0]), .rd0_req_ready(rq_rdy[0]), .rd0_req_addr(rq_a[0]), .rd0_req_mask(rq_m[0]),
    .rd0_resp_valid(rs_v[0]), .rd0_resp_ready(rs_rdy[0]), .rd0_resp_data(rs_d[0]),
    .rd1_req_valid(rq_v[1]), .rd1_req_ready(rq_rdy[1]), .rd1_req_addr(rq_a[1]), .rd1_req_mask(rq_m[1]),
    .rd1_resp_valid(rs_v[1]), .rd1_resp_ready(rs_rdy[1]), .rd1_resp_data(rs_d[1]),
    .wr_req_valid(wv), .wr_req_ready(wrdy), .wr_req_addr(wa), .wr_req_data(wd), .wr_req_mask(wm),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_mask(ram_rd_mask), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_mask(ram_wr_mask)
  );

  // Behavioural RAM: registered, masked read; partition-masked write.
  logic          mem_init;
  logic [DW-1:0] mem [SZ];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < SZ; i++) mem[i] <= '0;
    end else if (ram_wr_en) begin
      for (int p = 0; p < NP; p++)
        if (ram_wr_mask[p]) mem[ram_wr_addr][p*PW +: PW] <= ram_wr_data[p*PW +: PW];
    end
    if (ram_rd_en)
      for (int p = 0; p < NP; p++)
        ram_rd_data[p*PW +: PW] <= ram_rd_mask[p] ? mem[ram_rd_addr][p*PW +: PW] : '0;
  end

  // Reference model state
  int            m_prio;
  bit [1:0]      m_pend, m_rv;
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] m_pd [2];
  logic [DW-1:0] ref_mem [SZ];
  int            g_cur;
  int            vec = 0, errs = 0;

  function automatic logic [DW-1:0] mexp(input logic [NP-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) if (m[p]) r[p*PW +: PW] = '1;
    return r;
  endfunction

  function automatic int model_grant();
    bit [2:0] el;
    if (!rst) return -1;
    for (int n = 0; n < 2; n++) el[n] = rq_v[n] && !m_pend[n] && (!m_rv[n] || rs_rdy[n]);
    el[2] = wv;
    for (int k = 0; k < 3; k++) if (el[(m_prio + k) % 3]) return (m_prio + k) % 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_prio = 0; m_pend = '0; m_rv = '0;
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  // Settle just after the falling edge, then predict this cycle's grant.
  task automatic cyc();
    #1;
    if (!rst) model_reset();
    g_cur = model_grant();
  endtask

  // Apply this cycle's effects to the model and move to the next falling edge.
  task automatic adv();
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        if (m_pend[n]) begin m_rv[n] = 1'b1; m_rd[n] = m_pd[n]; end
        else if (m_rv[n] && rs_rdy[n]) m_rv[n] = 1'b0;
      end
      m_pend = '0;
      if (g_cur == 0 || g_cur == 1) begin
        m_pend[g_cur] = 1'b1;
        m_pd[g_cur]   = ref_mem[rq_a[g_cur]] & mexp(rq_m[g_cur]);
      end
      if (g_cur == 2) ref_mem[wa] = (ref_mem[wa] & ~mexp(wm)) | (wd & mexp(wm));
      if (g_cur >= 0) m_prio = (g_cur + 1) % 3;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc(); adv(); rst = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NP-1:0] m);
    int t;
    t = 0;
    wv = 1'b1; wa = a; wd = d; wm = m;
    cyc();
    while (wrdy !== 1'b1 && t < 10) begin adv(); cyc(); t++; end
    vec++;
    if (wrdy !== 1'b1) begin errs++; $display("FAIL write_grant_timeout addr=%0d got ready=%b exp 1", a, wrdy); end
    adv();
    wv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_init = 1'b1;
    rq_v = '1; wv = 1'b1; rs_rdy = '1; rq_a = '0; rq_m = '1; wa = '0; wd = '0; wm = '1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cyc();
      vec++;
      if ({wrdy, rq_rdy, ram_wr_en, ram_rd_en} !== 5'b0) begin
        errs++; $display("FAIL reset_grants got %b exp 00000", {wrdy, rq_rdy, ram_wr_en, ram_rd_en});
      end
      vec++;
      if ({rs_v, rs_d} !== 10'b0) begin errs++; $display("FAIL reset_resp got %h exp 000", {rs_v, rs_d}); end
      adv();
    end
    mem_init = 1'b0; rq_v = '0; wv = 1'b0; rst = 1'b1;
  endtask

  task automatic test_single_read();
    do_write(5'd5, 4'hA, 2'b11);
    rq_v[0] = 1'b1; rq_a[0] = 5'd5; rq_m[0] = 2'b11;
    cyc();
    vec++; if (rq_rdy[0] !== 1'b1) begin errs++; $display("FAIL single_read_ready got %b exp 1", rq_rdy[0]); end
    adv(); rq_v[0] = 1'b0;
    cyc();
    vec++; if (rs_v[0] !== 1'b0) begin errs++; $display("FAIL single_read_early got %b exp 0", rs_v[0]); end
    adv();
    cyc();
    vec++;
    if ({rs_v[0], rs_d[0]} !== {1'b1, 4'hA}) begin
      errs++; $display("FAIL single_read_resp got v=%b d=%h exp v=1 d=a", rs_v[0], rs_d[0]);
    end
    adv();
  endtask

  task automatic test_rotation();
    logic [2:0] exp_oh;
    do_reset();
    rq_v = '1; wv = 1'b1; rs_rdy = '1; rq_m = '1; wm = '1;
    rq_a[0] = 5'd1; rq_a[1] = 5'd2; wa = 5'd3; wd = 4'h5;
    for (int k = 0; k < 9; k++) begin
      cyc();
      exp_oh = 3'b001 << (k % 3);
      vec++;
      if ({wrdy, rq_rdy} !== exp_oh) begin
        errs++; $display("FAIL rotation_grant cycle=%0d got %b exp %b", k, {wrdy, rq_rdy}, exp_oh);
      end
      adv();
    end
    rq_v = '0; wv = 1'b0;
    repeat (2) begin cyc(); adv(); end
  endtask

  task automatic test_backpressure();
    do_write(5'd9, 4'h6, 2'b11);
    do_write(5'd10, 4'h9, 2'b11);
    rs_rdy[1] = 1'b0; rq_v[1] = 1'b1; rq_a[1] = 5'd9; rq_m[1] = 2'b11;
    cyc();
    vec++; if (rq_rdy[1] !== 1'b1) begin errs++; $display("FAIL bp_first_grant got %b exp 1", rq_rdy[1]); end
    adv();
    rq_a[1] = 5'd10;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      vec++; if (rq_rdy[1] !== 1'b0) begin errs++; $display("FAIL bp_no_regrant cycle=%0d got %b exp 0", k, rq_rdy[1]); end
      if (k >= 2) begin
        vec++;
        if ({rs_v[1], rs_d[1]} !== {1'b1, 4'h6}) begin
          errs++; $display("FAIL bp_hold cycle=%0d got v=%b d=%h exp v=1 d=6", k, rs_v[1], rs_d[1]);
        end
      end
      adv();
    end
    rs_rdy[1] = 1'b1;
    cyc();
    vec++;
    if ({rq_rdy[1], rs_v[1], rs_d[1]} !== {2'b11, 4'h6}) begin
      errs++; $display("FAIL bp_release got rdy=%b v=%b d=%h exp rdy=1 v=1 d=6", rq_rdy[1], rs_v[1], rs_d[1]);
    end
    adv(); rq_v[1] = 1'b0;
    cyc();
    vec++; if (rs_v[1] !== 1'b0) begin errs++; $display("FAIL bp_gap got %b exp 0", rs_v[1]); end
    adv();
    cyc();
    vec++;
    if ({rs_v[1], rs_d[1]} !== {1'b1, 4'h9}) begin
      errs++; $display("FAIL bp_next got v=%b d=%h exp v=1 d=9", rs_v[1], rs_d[1]);
    end
    adv();
  endtask

  task automatic test_write_then_read();
    logic [DW-1:0] pre [3] = '{4'h0, 4'hF, 4'hF};
    logic [DW-1:0] dat [3] = '{4'h3, 4'h3, 4'h0};
    logic [NP-1:0] msk [3] = '{2'b11, 2'b01, 2'b01};
    logic [DW-1:0] exp [3] = '{4'h3, 4'hF, 4'hC};
    for (int i = 0; i < 3; i++) begin
      do_write(5'd7, pre[i], 2'b11);
      wv = 1'b1; wa = 5'd7; wd = dat[i]; wm = msk[i];
      cyc();
      vec++; if (wrdy !== 1'b1) begin errs++; $display("FAIL wtr_write_grant case=%0d got %b exp 1", i, wrdy); end
      adv(); wv = 1'b0;
      rq_v[0] = 1'b1; rq_a[0] = 5'd7; rq_m[0] = 2'b11;
      cyc();
      vec++; if (rq_rdy[0] !== 1'b1) begin errs++; $display("FAIL wtr_read_grant case=%0d got %b exp 1", i, rq_rdy[0]); end
      adv(); rq_v[0] = 1'b0;
      cyc(); adv();
      cyc();
      vec++;
      if ({rs_v[0], rs_d[0]} !== {1'b1, exp[i]}) begin
        errs++; $display("FAIL wtr_resp case=%0d got v=%b d=%h exp v=1 d=%h", i, rs_v[0], rs_d[0], exp[i]);
      end
      adv();
    end
  endtask

  task automatic test_masked_read();
    logic [NP-1:0] msk [2] = '{2'b10, 2'b01};
    logic [DW-1:0] exp [2] = '{4'hC, 4'h3};
    do_write(5'd2, 4'hF, 2'b11);
    for (int i = 0; i < 2; i++) begin
      rq_v[0] = 1'b1; rq_a[0] = 5'd2; rq_m[0] = msk[i];
      cyc(); adv(); rq_v[0] = 1'b0;
      cyc(); adv();
      cyc();
      vec++;
      if ({rs_v[0], rs_d[0]} !== {1'b1, exp[i]}) begin
        errs++; $display("FAIL masked_read mask=%b got v=%b d=%h exp v=1 d=%h", msk[i], rs_v[0], rs_d[0], exp[i]);
      end
      adv();
    end
  endtask

  task automatic test_reset_mid_read();
    logic [2:0] exp_oh;
    rs_rdy = '1;
    rq_v[0] = 1'b1; rq_a[0] = 5'd2; rq_m[0] = 2'b11;
    cyc();
    vec++; if (rq_rdy[0] !== 1'b1) begin errs++; $display("FAIL rmr_grant got %b exp 1", rq_rdy[0]); end
    adv();
    rst = 1'b0; rq_v = '1; wv = 1'b1; rq_a[1] = 5'd3; rq_m[1] = 2'b11; wa = 5'd4; wd = 4'h1; wm = 2'b11;
    for (int k = 0; k < 2; k++) begin
      cyc();
      vec++;
      if ({wrdy, rq_rdy, ram_wr_en, ram_rd_en} !== 5'b0) begin
        errs++; $display("FAIL rmr_in_reset got %b exp 00000", {wrdy, rq_rdy, ram_wr_en, ram_rd_en});
      end
      adv();
    end
    rst = 1'b1; rq_v = '0; wv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vec++; if (rs_v[0] !== 1'b0) begin errs++; $display("FAIL rmr_no_resp cycle=%0d got %b exp 0", k, rs_v[0]); end
      adv();
    end
    rq_v = '1; wv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      exp_oh = 3'b001 << k;
      vec++;
      if ({wrdy, rq_rdy} !== exp_oh) begin
        errs++; $display("FAIL rmr_after_grant cycle=%0d got %b exp %b", k, {wrdy, rq_rdy}, exp_oh);
      end
      adv();
      if (k == 0) rq_v[0] = 1'b0;
      if (k == 1) rq_v[1] = 1'b0;
    end
    wv = 1'b0;
    repeat (3) begin cyc(); adv(); end
  endtask

  task automatic test_random();
    logic [2:0] exp_oh;
    int         g;
    for (int c = 0; c < 500; c++) begin
      for (int n = 0; n < 2; n++)
        if (!rq_v[n] && $urandom_range(0, 2) != 0) begin
          rq_v[n] = 1'b1;
          rq_a[n] = AW'($urandom_range(0, SZ - 1));
          rq_m[n] = NP'($urandom_range(0, 3));
        end
      if (!wv && $urandom_range(0, 2) == 0) begin
        wv = 1'b1;
        wa = AW'($urandom_range(0, SZ - 1));
        wd = DW'($urandom_range(0, 15));
        wm = NP'($urandom_range(0, 3));
      end
      rs_rdy = 2'($urandom_range(0, 3));
      cyc();
      exp_oh = (g_cur < 0) ? 3'b000 : 3'(1 << g_cur);
      vec++;
      if ({wrdy, rq_rdy, ram_wr_en, ram_rd_en} !== {exp_oh, exp_oh[2], |exp_oh[1:0]}) begin
        errs++; $display("FAIL rand_grant cycle=%0d got %b exp %b", c, {wrdy, rq_rdy, ram_wr_en, ram_rd_en},
                         {exp_oh, exp_oh[2], |exp_oh[1:0]});
      end
      if (g_cur == 0 || g_cur == 1) begin
        vec++;
        if ({ram_rd_addr, ram_rd_mask} !== {rq_a[g_cur], rq_m[g_cur]}) begin
          errs++; $display("FAIL rand_rd_port cycle=%0d got %h exp %h", c, {ram_rd_addr, ram_rd_mask},
                           {rq_a[g_cur], rq_m[g_cur]});
        end
      end
      if (g_cur == 2) begin
        vec++;
        if ({ram_wr_addr, ram_wr_data, ram_wr_mask} !== {wa, wd, wm}) begin
          errs++; $display("FAIL rand_wr_port cycle=%0d got %h exp %h", c, {ram_wr_addr, ram_wr_data, ram_wr_mask},
                           {wa, wd, wm});
        end
      end
      vec++;
      if (rs_v !== m_rv) begin errs++; $display("FAIL rand_resp_valid cycle=%0d got %b exp %b", c, rs_v, m_rv); end
      for (int n = 0; n < 2; n++)
        if (m_rv[n]) begin
          vec++;
          if (rs_d[n] !== m_rd[n]) begin
            errs++; $display("FAIL rand_resp_data port=%0d cycle=%0d got %h exp %h", n, c, rs_d[n], m_rd[n]);
          end
        end
      g = g_cur;
      adv();
      if (g == 0 || g == 1) rq_v[g] = 1'b0;
      if (g == 2) wv = 1'b0;
    end
    rq_v = '0; wv = 1'b0; rs_rdy = '1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < SZ; i++) ref_mem[i] = '0;
    m_pd[0] = '0; m_pd[1] = '0;
    model_reset();
    g_cur = -1;
    test_reset();
    test_single_read();
    test_rotation();
    test_backpressure();
    test_write_then_read();
    test_masked_read();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
